// File: rtl/sr_pkg.sv
// Shared constants and next-state function for the SR flip-flop bank.
// Conflict policy encodings select what a channel does when S and R are both effective.
package sr_pkg;

    localparam logic [1:0] CM_HOLD   = 2'd0;
    localparam logic [1:0] CM_SET    = 2'd1;
    localparam logic [1:0] CM_RESET  = 2'd2;
    localparam logic [1:0] CM_TOGGLE = 2'd3;

    function automatic logic sr_next_q(
        input logic       q,
        input logic       es,
        input logic       er,
        input logic [1:0] mode
    );
        logic nq;
        nq = q;
        case ({es, er})
            2'b10:   nq = 1'b1;
            2'b01:   nq = 1'b0;
            2'b11: begin
                case (mode)
                    CM_HOLD:  nq = q;
                    CM_SET:   nq = 1'b1;
                    CM_RESET: nq = 1'b0;
                    default:  nq = ~q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: optional edge qualification, enable, conflict policy and
// separately registered q/qn, plus a flag for an effective S=R=1 this cycle.
module sr_ff_cell
    import sr_pkg::*;
#(
    parameter int   CONFLICT_MODE = 1,
    parameter int   EDGE_MODE     = 0,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s,
    input  logic i_r,
    input  logic i_en,
    input  logic i_sync_clr,
    output logic o_q,
    output logic o_qn,
    output logic o_hit
);

    localparam logic [1:0] MODE = CONFLICT_MODE[1:0];

    logic r_s_prev;
    logic r_r_prev;
    logic r_q;
    logic r_qn;
    logic w_es;
    logic w_er;
    logic w_q_next;

    // History tracks raw inputs every cycle, independent of enable and sync clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_prev <= 1'b0;
            r_r_prev <= 1'b0;
        end else begin
            r_s_prev <= i_s;
            r_r_prev <= i_r;
        end
    end

    assign w_es = (EDGE_MODE != 0) ? (i_s & ~r_s_prev) : i_s;
    assign w_er = (EDGE_MODE != 0) ? (i_r & ~r_r_prev) : i_r;

    always_comb begin
        w_q_next = r_q;
        if (i_sync_clr)
            w_q_next = RESET_VAL;
        else if (i_en)
            w_q_next = sr_next_q(r_q, w_es, w_er, MODE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q  <= RESET_VAL;
            r_qn <= ~RESET_VAL;
        end else begin
            r_q  <= w_q_next;
            r_qn <= ~w_q_next;
        end
    end

    assign o_q   = r_q;
    assign o_qn  = r_qn;
    assign o_hit = i_en & ~i_sync_clr & w_es & w_er;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH SR flip-flops with a sticky per-channel conflict flag and a
// saturating count of cycles in which any channel saw an effective conflict.
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 1,
    parameter int               EDGE_MODE     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] en,
    input  logic             sync_clr,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3 || WIDTH < 1) begin : g_param_err
        $error("sr_ff_bank: CONFLICT_MODE must be 0..3 and WIDTH >= 1");
    end

    logic [WIDTH-1:0] w_hit;
    logic             w_any_hit;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell #(
            .CONFLICT_MODE (CONFLICT_MODE),
            .EDGE_MODE     (EDGE_MODE),
            .RESET_VAL     (RESET_VAL[i])
        ) u_cell (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_s        (s[i]),
            .i_r        (r[i]),
            .i_en       (en[i]),
            .i_sync_clr (sync_clr),
            .o_q        (q[i]),
            .o_qn       (qn[i]),
            .o_hit      (w_hit[i])
        );
    end

    assign w_any_hit = |w_hit;

    // A clear coinciding with a new conflict keeps only that cycle's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
            r_cnt    <= '0;
        end else if (conflict_clr) begin
            r_sticky <= w_hit;
            r_cnt    <= CNT_W'(w_any_hit);
        end else begin
            r_sticky <= r_sticky | w_hit;
            if (w_any_hit && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign conflict_sticky = r_sticky;
    assign conflict_cnt    = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: several parameterisations share one stimulus bus.
module tb_sr_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s, r, en;
    logic       sync_clr, conflict_clr;

    logic [7:0] q_m0, qn_m0, st_m0;  logic [7:0] cnt_m0;
    logic [7:0] q_m1, qn_m1, st_m1;  logic [7:0] cnt_m1;
    logic [7:0] q_m2, qn_m2, st_m2;  logic [7:0] cnt_m2;
    logic [7:0] q_m3, qn_m3, st_m3;  logic [7:0] cnt_m3;
    logic [7:0] q_e,  qn_e,  st_e;   logic [7:0] cnt_e;
    logic [7:0] q_c,  qn_c,  st_c;   logic [1:0] cnt_c;

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(0), .EDGE_MODE(0), .CNT_W(8)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_m0), .qn(qn_m0), .conflict_sticky(st_m0), .conflict_cnt(cnt_m0));
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .EDGE_MODE(0), .CNT_W(8)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_m1), .qn(qn_m1), .conflict_sticky(st_m1), .conflict_cnt(cnt_m1));
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(2), .EDGE_MODE(0), .CNT_W(8)) dut_m2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_m2), .qn(qn_m2), .conflict_sticky(st_m2), .conflict_cnt(cnt_m2));
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(3), .EDGE_MODE(0), .CNT_W(8)) dut_m3 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_m3), .qn(qn_m3), .conflict_sticky(st_m3), .conflict_cnt(cnt_m3));
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .EDGE_MODE(1), .CNT_W(8)) dut_e (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_e), .qn(qn_e), .conflict_sticky(st_e), .conflict_cnt(cnt_e));
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(1), .EDGE_MODE(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .sync_clr(sync_clr),
        .conflict_clr(conflict_clr), .q(q_c), .qn(qn_c), .conflict_sticky(st_c), .conflict_cnt(cnt_c));

    // Returns 1 ns after a rising edge; inputs set here are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s = '0; r = '0; en = 8'hFF; sync_clr = 1'b0; conflict_clr = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        ntotal++;
        if ({q_m1, qn_m1, st_m1, cnt_m1} !== {8'h00, 8'hFF, 8'h00, 8'h00})
            $display("FAIL reset_initial: got q=%h qn=%h st=%h cnt=%0d want 00 ff 00 0", q_m1, qn_m1, st_m1, cnt_m1);
        else npass++;
        rst_n = 1'b1;
        s = 8'hA5;
        tick();
        s = 8'h01; r = 8'h01;
        tick();
        ntotal++;
        if ({q_m1, st_m1, cnt_m1} !== {8'hA5, 8'h01, 8'd1})
            $display("FAIL reset_preload: got q=%h st=%h cnt=%0d want a5 01 1", q_m1, st_m1, cnt_m1);
        else npass++;
        s = '0; r = '0;
        #2 rst_n = 1'b0;
        #1;
        ntotal++;
        if ({q_m1, qn_m1, st_m1, cnt_m1} !== {8'h00, 8'hFF, 8'h00, 8'h00})
            $display("FAIL reset_midop: got q=%h qn=%h st=%h cnt=%0d want 00 ff 00 0", q_m1, qn_m1, st_m1, cnt_m1);
        else npass++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        pulse_reset();
        s = 8'h0F;
        tick();
        ntotal++;
        if ({q_m1, qn_m1} !== {8'h0F, 8'hF0})
            $display("FAIL basic_set: got q=%h qn=%h want 0f f0", q_m1, qn_m1);
        else npass++;
        s = 8'h00; r = 8'h03;
        tick();
        ntotal++;
        if ({q_m1, qn_m1} !== {8'h0C, 8'hF3})
            $display("FAIL basic_reset: got q=%h qn=%h want 0c f3", q_m1, qn_m1);
        else npass++;
        r = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            ntotal++;
            if (q_m1 !== 8'h0C)
                $display("FAIL basic_hold%0d: got q=%h want 0c", i, q_m1);
            else npass++;
        end
    endtask

    task automatic test_conflict_modes();
        logic [2:0] e0, e1, e2, e3;
        e0 = 3'b000; e1 = 3'b111; e2 = 3'b000; e3 = 3'b101;
        pulse_reset();
        s = 8'h01; r = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            ntotal++;
            if ({q_m0[0], q_m1[0], q_m2[0], q_m3[0]} !== {e0[i], e1[i], e2[i], e3[i]})
                $display("FAIL conflict_q_cyc%0d: got m0..m3=%b%b%b%b want %b%b%b%b", i,
                         q_m0[0], q_m1[0], q_m2[0], q_m3[0], e0[i], e1[i], e2[i], e3[i]);
            else npass++;
        end
        ntotal++;
        if ({st_m0, st_m1, st_m2, st_m3} !== {4{8'h01}})
            $display("FAIL conflict_sticky: got %h %h %h %h want 01 each", st_m0, st_m1, st_m2, st_m3);
        else npass++;
        ntotal++;
        if ({cnt_m0, cnt_m1, cnt_m2, cnt_m3} !== {4{8'd3}})
            $display("FAIL conflict_cnt: got %0d %0d %0d %0d want 3 each", cnt_m0, cnt_m1, cnt_m2, cnt_m3);
        else npass++;
        ntotal++;
        if (qn_m3[0] !== 1'b0)
            $display("FAIL conflict_toggle_qn: got qn0=%b want 0", qn_m3[0]);
        else npass++;
    endtask

    task automatic test_edge_mode();
        logic [3:0] exp_q2;
        exp_q2 = 4'b0011;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            s = 8'h04;
            r = (i == 2) ? 8'h04 : 8'h00;
            tick();
            ntotal++;
            if (q_e[2] !== exp_q2[i])
                $display("FAIL edge_q2_clk%0d: got %b want %b", i + 1, q_e[2], exp_q2[i]);
            else npass++;
        end
        ntotal++;
        if ({st_e, cnt_e} !== {8'h00, 8'd0})
            $display("FAIL edge_no_conflict: got st=%h cnt=%0d want 00 0", st_e, cnt_e);
        else npass++;
    endtask

    task automatic test_enable_syncclr();
        pulse_reset();
        en = 8'hF0; s = 8'hFF;
        tick();
        ntotal++;
        if (q_m1 !== 8'hF0)
            $display("FAIL enable_mask: got q=%h want f0", q_m1);
        else npass++;
        r = 8'hFF;
        tick();
        ntotal++;
        if ({q_m1, st_m1, cnt_m1} !== {8'hF0, 8'hF0, 8'd1})
            $display("FAIL enable_conflict: got q=%h st=%h cnt=%0d want f0 f0 1", q_m1, st_m1, cnt_m1);
        else npass++;
        en = 8'hFF; sync_clr = 1'b1;
        tick();
        ntotal++;
        if ({q_m1, qn_m1, st_m1, cnt_m1} !== {8'h00, 8'hFF, 8'hF0, 8'd1})
            $display("FAIL sync_clr: got q=%h qn=%h st=%h cnt=%0d want 00 ff f0 1", q_m1, qn_m1, st_m1, cnt_m1);
        else npass++;
        sync_clr = 1'b0;
    endtask

    task automatic test_saturation_clear();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        pulse_reset();
        s = 8'h01; r = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            ntotal++;
            if (cnt_c !== exp_cnt[i])
                $display("FAIL sat_cnt_clk%0d: got %0d want %0d", i + 1, cnt_c, exp_cnt[i]);
            else npass++;
        end
        s = 8'h10; r = 8'h10; conflict_clr = 1'b1;
        tick();
        ntotal++;
        if ({st_c, cnt_c} !== {8'h10, 2'd1})
            $display("FAIL clr_race: got st=%h cnt=%0d want 10 1", st_c, cnt_c);
        else npass++;
        s = 8'h00; r = 8'h00;
        tick();
        ntotal++;
        if ({st_c, cnt_c, q_c} !== {8'h00, 2'd0, 8'h11})
            $display("FAIL clr_alone: got st=%h cnt=%0d q=%h want 00 0 11", st_c, cnt_c, q_c);
        else npass++;
        conflict_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conflict_modes();
        test_edge_mode();
        test_enable_syncclr();
        test_saturation_clear();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
